vram_scanout: RTL
=================

// Module: vram_scanout
// PURPOSE
//  Display-side reader of the 128x64x2-bit VRAM the CPU draws into. Generates 640x480 raster timing,
//  reads VRAM through a second synchronous read port and converts pixels to RGB with sync and DE.
//  Drives the vsync the CPU uses for its 60 Hz timers, key scan and instruction pacing.
//  Sits between the VRAM read port and the board video DAC/encoder.
// PARAMETERS
//  CLK_DIV    1       clk cycles per raster pixel (raster counters advance every CLK_DIV clk)
//  H_VIS/H_FP/H_SYNC/H_BP  640/16/96/48  horizontal timing, pixels
//  V_VIS/V_FP/V_SYNC/V_BP  480/10/2/33   vertical timing, lines
//  SCALE      4       raster pixels per hires VRAM pixel; power of 2; lores uses 2*SCALE
//  SYNC_NEG   1       1 = hsync/vsync active low
//  PAL0..PAL3 12'h000,12'h0F0,12'h0F0,12'hFFF  RGB444 for VRAM pixel values 0..3
//  BORDER     12'h111 RGB inside the visible area but outside the framebuffer window
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous reset, active low
//  hires         in   1   1 = 128x64 mode, 0 = 64x32 mode (CPU writes lores in top-left 64x32)
//  vram_rd_hpos  out  7   VRAM read column
//  vram_rd_vpos  out  6   VRAM read row
//  vram_rd_pixel in   2   VRAM read data, valid 1 clk after address (synchronous RAM)
//  hsync         out  1   horizontal sync, polarity per SYNC_NEG
//  vsync         out  1   vertical sync, polarity per SYNC_NEG (to CPU)
//  de            out  1   display enable: high for the 640x480 visible area
//  rgb           out  12  pixel colour RGB444; 0 when de low
// BEHAVIOUR
//  Reset: counters 0, divider 0, hsync/vsync inactive level, de 0, rgb 0, vram_rd_* 0, hires_q 0.
//  Raster: h_cnt 0..H_TOTAL-1 (800), v_cnt 0..V_TOTAL-1 (525), stepped on divider enable.
//   h_cnt wraps to 0 and increments v_cnt. Both wrap at end of frame.
//   Sync active for h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC) and likewise for v_cnt.
//  Window: X_OFF=(H_VIS-128*SCALE)/2=64, Y_OFF=(V_VIS-64*SCALE)/2=112. Window is 512x256.
//   hires_q=1: col=(h-X_OFF)>>log2(SCALE), row=(v-Y_OFF)>>log2(SCALE).
//   hires_q=0: same with shift log2(SCALE)+1, so col<=63 and row<=31.
//   Outside the window: vram_rd_* hold their last value (don't care).
//  Pipeline, every clk, no stalls:
//   S0 counters -> S1 vram_rd_* registered, plus in_win/vis/sync flags -> S2 RAM data returns
//   -> S3 rgb/de/hsync/vsync registered together.
//   All outputs therefore lag the counters by 3 clk and stay mutually aligned.
//  Colour at S3: !vis -> 0. vis && !in_win -> BORDER. Otherwise PALn[vram_rd_pixel].
//  hires is sampled into hires_q only on the clk where v_cnt wraps to 0 at h_cnt 0.
//   A mid-frame mode change takes effect at the next frame; no tearing.
//  Read port is read-only: the block never drives a write enable.
//   CPU writes on the other port may be visible within the same frame (accepted tearing).
//  Reset mid-line: all outputs return to reset values immediately (async).
//   Raster restarts at (0,0) on the first clk after release.
// STRUCTURE
//  Package vram_video_pkg: timing constants, H_TOTAL/V_TOTAL, window offsets, default palette.
//   The CPU and the VRAM wrapper share its VRAM width constants (128, 64, 2-bit pixels).
//  Sub-module raster_timing: divider, h/v counters, sync/vis flags.
//   vram_scanout adds the address mapping, pipeline and palette.
// TESTING
//  Timing, CLK_DIV=1: hsync falling edges 800 clk apart; hsync low 96 clk.
//   vsync low 1600 clk; vsync period 420000 clk. CLK_DIV=2 doubles all of these.
//  Hires addressing: at h=64+4*10, v=112+4*5 -> vram_rd_hpos=10, vram_rd_vpos=5 one clk later.
//   Model returns 2'd3 -> rgb=12'hFFF, de=1 three clk after the counters hit that point.
//  Lores addressing: h=64+8*10, v=112+8*5 -> hpos=10, vpos=5.
//   Over a full frame, no address exceeds hpos 63 or vpos 31.
//  Border and blanking: (h,v)=(10,10) -> de=1, rgb=12'h111.
//   h=700 -> de=0, rgb=0. v=500 -> de=0.
//  Mode latch: toggle hires 0->1 at v=200 -> mapping stays lores until the next v_cnt wrap,
//   then hires mapping applies.
//  Reset mid-frame: rst_n low at h=300, v=150 -> outputs immediately at reset values.
//   After release the first hsync falls 656+3 clk later.

Source files
------------

// File: rtl/vram_video_pkg.sv
// Shared video/VRAM constants: framebuffer geometry, default 640x480 raster
// timing, window offset helper, default palette and the pipeline flag bundle.
package vram_video_pkg;

    // VRAM geometry, shared with the CPU and the VRAM wrapper.
    localparam int VRAM_W = 128;
    localparam int VRAM_H = 64;
    localparam int PIX_W  = 2;
    localparam int HPOS_W = 7;
    localparam int VPOS_W = 6;

    // Raster counters are 10 bits wide; every supported total fits in 1024.
    localparam int CNT_W = 10;
    localparam int RGB_W = 12;

    // Default 640x480 timing.
    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;
    localparam int DEF_H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Default palette (RGB444) and border colour.
    localparam logic [RGB_W-1:0] DEF_PAL0   = 12'h000;
    localparam logic [RGB_W-1:0] DEF_PAL1   = 12'h0F0;
    localparam logic [RGB_W-1:0] DEF_PAL2   = 12'h0F0;
    localparam logic [RGB_W-1:0] DEF_PAL3   = 12'hFFF;
    localparam logic [RGB_W-1:0] DEF_BORDER = 12'h111;

    // Offset that centres a span of 'span' pixels inside 'vis' pixels.
    function automatic int win_off(input int vis, input int span);
        return (vis - span) / 2;
    endfunction

    // Per-pixel flags carried down the pipeline next to the VRAM access.
    typedef struct packed {
        logic vis;
        logic in_win;
        logic hs;
        logic vs;
    } flags_t;

endpackage

// File: rtl/raster_timing.sv
// Raster timing generator: clock divider, horizontal/vertical counters and the
// combinational visible/sync flags decoded from the current counter values.
module raster_timing
    import vram_video_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int H_VIS   = DEF_H_VIS,
    parameter int H_FP    = DEF_H_FP,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BP    = DEF_H_BP,
    parameter int V_VIS   = DEF_V_VIS,
    parameter int V_FP    = DEF_V_FP,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BP    = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             frame_wrap,
    output logic             vis,
    output logic             hs_act,
    output logic             vs_act
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic             step;
    logic             h_last;
    logic             v_last;

    assign step   = (div_cnt == DIV_LAST);
    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // Pixel divider: 'step' is high for one clk out of every CLK_DIV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (step) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Raster position: h wraps into v, both wrap together at end of frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (step) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Flags decoded from the counters; the consumer registers them.
    always_comb begin
        frame_wrap = step && h_last && v_last;
        vis        = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
        hs_act     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_act     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    end

endmodule

// File: rtl/vram_scanout.sv
// Display-side VRAM reader: maps raster position to VRAM coordinates, reads the
// synchronous RAM port and produces RGB444, DE and syncs through a 3-clk
// pipeline whose outputs stay mutually aligned.
module vram_scanout
    import vram_video_pkg::*;
#(
    parameter int               CLK_DIV  = 1,
    parameter int               H_VIS    = DEF_H_VIS,
    parameter int               H_FP     = DEF_H_FP,
    parameter int               H_SYNC   = DEF_H_SYNC,
    parameter int               H_BP     = DEF_H_BP,
    parameter int               V_VIS    = DEF_V_VIS,
    parameter int               V_FP     = DEF_V_FP,
    parameter int               V_SYNC   = DEF_V_SYNC,
    parameter int               V_BP     = DEF_V_BP,
    parameter int               SCALE    = 4,
    parameter int               SYNC_NEG = 1,
    parameter logic [RGB_W-1:0] PAL0     = DEF_PAL0,
    parameter logic [RGB_W-1:0] PAL1     = DEF_PAL1,
    parameter logic [RGB_W-1:0] PAL2     = DEF_PAL2,
    parameter logic [RGB_W-1:0] PAL3     = DEF_PAL3,
    parameter logic [RGB_W-1:0] BORDER   = DEF_BORDER
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hires,
    output logic [HPOS_W-1:0] vram_rd_hpos,
    output logic [VPOS_W-1:0] vram_rd_vpos,
    input  logic [PIX_W-1:0]  vram_rd_pixel,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [RGB_W-1:0]  rgb
);

    localparam int WIN_W  = VRAM_W * SCALE;
    localparam int WIN_H  = VRAM_H * SCALE;
    localparam int X_OFF  = win_off(H_VIS, WIN_W);
    localparam int Y_OFF  = win_off(V_VIS, WIN_H);
    localparam int SH_HI  = $clog2(SCALE);
    localparam int SH_LO  = SH_HI + 1;

    localparam logic [CNT_W-1:0] X_LO = CNT_W'(X_OFF);
    localparam logic [CNT_W-1:0] X_HI = CNT_W'(X_OFF + WIN_W);
    localparam logic [CNT_W-1:0] Y_LO = CNT_W'(Y_OFF);
    localparam logic [CNT_W-1:0] Y_HI = CNT_W'(Y_OFF + WIN_H);

    // Level driven on hsync/vsync while the pulse is not active.
    localparam logic SYNC_IDLE = (SYNC_NEG != 0);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             frame_wrap;
    logic             vis;
    logic             hs_act;
    logic             vs_act;
    logic             hires_q;
    logic             in_win;
    logic [CNT_W-1:0] h_rel;
    logic [CNT_W-1:0] v_rel;
    flags_t           s0_flags;
    flags_t           s1_flags;
    flags_t           s2_flags;
    logic [RGB_W-1:0] pal_rgb;

    raster_timing #(
        .CLK_DIV (CLK_DIV),
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .frame_wrap (frame_wrap),
        .vis        (vis),
        .hs_act     (hs_act),
        .vs_act     (vs_act)
    );

    // Window decode and window-relative coordinates at the counter stage.
    always_comb begin
        in_win   = (h_cnt >= X_LO) && (h_cnt < X_HI) && (v_cnt >= Y_LO) && (v_cnt < Y_HI);
        h_rel    = h_cnt - X_LO;
        v_rel    = v_cnt - Y_LO;
        s0_flags = '{vis: vis, in_win: in_win, hs: hs_act, vs: vs_act};
    end

    // Mode is only latched as the raster wraps to (0,0), so a frame never mixes modes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hires_q <= 1'b0;
        end else if (frame_wrap) begin
            hires_q <= hires;
        end
    end

    // S1: register the VRAM read address (held outside the window) and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_rd_hpos <= '0;
            vram_rd_vpos <= '0;
            s1_flags     <= '0;
        end else begin
            if (in_win) begin
                vram_rd_hpos <= hires_q ? HPOS_W'(h_rel >> SH_HI) : HPOS_W'(h_rel >> SH_LO);
                vram_rd_vpos <= hires_q ? VPOS_W'(v_rel >> SH_HI) : VPOS_W'(v_rel >> SH_LO);
            end
            s1_flags <= s0_flags;
        end
    end

    // S2: flags wait one clk while the RAM returns the pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_flags <= '0;
        end else begin
            s2_flags <= s1_flags;
        end
    end

    // Palette lookup on the returned VRAM pixel.
    always_comb begin
        pal_rgb = PAL0;
        case (vram_rd_pixel)
            2'd0:    pal_rgb = PAL0;
            2'd1:    pal_rgb = PAL1;
            2'd2:    pal_rgb = PAL2;
            default: pal_rgb = PAL3;
        endcase
    end

    // S3: all video outputs registered together so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= SYNC_IDLE;
            vsync <= SYNC_IDLE;
            de    <= 1'b0;
            rgb   <= '0;
        end else begin
            hsync <= s2_flags.hs ? ~SYNC_IDLE : SYNC_IDLE;
            vsync <= s2_flags.vs ? ~SYNC_IDLE : SYNC_IDLE;
            de    <= s2_flags.vis;
            if (!s2_flags.vis) begin
                rgb <= '0;
            end else if (!s2_flags.in_win) begin
                rgb <= BORDER;
            end else begin
                rgb <= pal_rgb;
            end
        end
    end

endmodule
